// File: rtl/frogger_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | frogger_pkg : shared scan-state encoding and playfield geometry         |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
package frogger_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int BLOCK   = 32;
  localparam int LANE_Y0 = 256;
  localparam int GOAL_Y  = 32;

  function automatic int lane_top(input int lane, input int y0, input int blk);
    return y0 + lane * blk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/collision_scanner_rect_overlap.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rect_overlap : per-axis overlap of two axis-aligned rectangles          |
// | Revision     : 1.0                                                      |
// +-------------------------------------------------------------------------+
module rect_overlap #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] aw,
  input  logic [COORD_W-1:0] ah,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] bw,
  input  logic [COORD_W-1:0] bh,
  output logic               x_overlap,
  output logic               y_overlap
);

  // Two guard bits so right/bottom edges near the coordinate limit never wrap.
  logic [COORD_W+1:0] a_x0, a_x1, a_y0, a_y1;
  logic [COORD_W+1:0] b_x0, b_x1, b_y0, b_y1;

  always_comb begin
    a_x0 = {2'b00, ax};
    a_y0 = {2'b00, ay};
    b_x0 = {2'b00, bx};
    b_y0 = {2'b00, by};
    a_x1 = a_x0 + {2'b00, aw};
    a_y1 = a_y0 + {2'b00, ah};
    b_x1 = b_x0 + {2'b00, bw};
    b_y1 = b_y0 + {2'b00, bh};
    x_overlap = (a_x0 < b_x1) && (a_x1 > b_x0);
    y_overlap = (a_y0 < b_y1) && (a_y1 > b_y0);
  end

endmodule
`default_nettype wire

// File: rtl/collision_scanner.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | collision_scanner : frame-synchronous frog-vs-car scan, one car/clock   |
// | Revision          : 1.0                                                 |
// +-------------------------------------------------------------------------+
module collision_scanner #(
  parameter int NUM_LANES     = 6,
  parameter int CARS_PER_LANE = 3,
  parameter int COORD_W       = 10,
  parameter int BLOCK         = frogger_pkg::BLOCK,
  parameter int LANE_Y0       = frogger_pkg::LANE_Y0,
  parameter int GOAL_Y        = frogger_pkg::GOAL_Y
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        start,
  input  logic [COORD_W-1:0]                          frog_x,
  input  logic [COORD_W-1:0]                          frog_y,
  input  logic [NUM_LANES*CARS_PER_LANE*COORD_W-1:0]  car_x,
  input  logic [NUM_LANES*COORD_W-1:0]                lane_len,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        hit,
  output logic [$clog2(NUM_LANES)-1:0]                hit_lane,
  output logic [$clog2(CARS_PER_LANE)-1:0]            hit_car,
  output logic                                        goal
);

  import frogger_pkg::*;

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int CAR_W  = $clog2(CARS_PER_LANE);
  localparam int NCARS  = NUM_LANES * CARS_PER_LANE;

  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [CAR_W-1:0]   LAST_CAR  = CAR_W'(CARS_PER_LANE - 1);
  localparam logic [COORD_W-1:0] BLOCK_C   = COORD_W'(BLOCK);
  localparam logic [COORD_W+1:0] GOAL_C    = (COORD_W+2)'(GOAL_Y);

  scan_state_t                 state_q, state_d;
  logic [COORD_W-1:0]          fx_q, fx_d, fy_q, fy_d;
  logic [NCARS*COORD_W-1:0]    car_x_q, car_x_d;
  logic [NUM_LANES*COORD_W-1:0] len_q, len_d;
  logic [LANE_W-1:0]           lane_q, lane_d, hit_lane_q, hit_lane_d;
  logic [CAR_W-1:0]            car_q, car_d, hit_car_q, hit_car_d;
  logic                        hit_q, hit_d, goal_q, goal_d;

  logic [COORD_W-1:0]          cur_x, cur_len, cur_ly;
  logic                        x_ovl, y_ovl;

  always_comb begin
    cur_x   = car_x_q[(int'(lane_q) * CARS_PER_LANE + int'(car_q)) * COORD_W +: COORD_W];
    cur_len = len_q[int'(lane_q) * COORD_W +: COORD_W];
    cur_ly  = COORD_W'(lane_top(int'(lane_q), LANE_Y0, BLOCK));
  end

  rect_overlap #(
    .COORD_W (COORD_W)
  ) u_overlap (
    .ax        (fx_q),
    .ay        (fy_q),
    .aw        (BLOCK_C),
    .ah        (BLOCK_C),
    .bx        (cur_x),
    .by        (cur_ly),
    .bw        (cur_len),
    .bh        (BLOCK_C),
    .x_overlap (x_ovl),
    .y_overlap (y_ovl)
  );

  always_comb begin
    state_d    = state_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    car_x_d    = car_x_q;
    len_d      = len_q;
    lane_d     = lane_q;
    car_d      = car_q;
    hit_d      = hit_q;
    hit_lane_d = hit_lane_q;
    hit_car_d  = hit_car_q;
    goal_d     = goal_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          fx_d       = frog_x;
          fy_d       = frog_y;
          car_x_d    = car_x;
          len_d      = lane_len;
          lane_d     = '0;
          car_d      = '0;
          hit_d      = 1'b0;
          hit_lane_d = '0;
          hit_car_d  = '0;
          goal_d     = ({2'b00, frog_y} < GOAL_C);
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // A lane the frog cannot touch vertically costs one cycle, not one per car.
        if (!y_ovl || (!x_ovl && car_q == LAST_CAR)) begin
          car_d = '0;
          if (lane_q == LAST_LANE) begin
            state_d = DONE;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end else if (x_ovl) begin
          hit_d      = 1'b1;
          hit_lane_d = lane_q;
          hit_car_d  = car_q;
          state_d    = DONE;
        end else begin
          car_d = car_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fx_q       <= '0;
      fy_q       <= '0;
      car_x_q    <= '0;
      len_q      <= '0;
      lane_q     <= '0;
      car_q      <= '0;
      hit_q      <= 1'b0;
      hit_lane_q <= '0;
      hit_car_q  <= '0;
      goal_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      car_x_q    <= car_x_d;
      len_q      <= len_d;
      lane_q     <= lane_d;
      car_q      <= car_d;
      hit_q      <= hit_d;
      hit_lane_q <= hit_lane_d;
      hit_car_q  <= hit_car_d;
      goal_q     <= goal_d;
    end
  end

  always_comb begin
    busy     = (state_q == SCAN);
    done     = (state_q == DONE);
    hit      = hit_q;
    hit_lane = hit_lane_q;
    hit_car  = hit_car_q;
    goal     = goal_q;
  end

endmodule
`default_nettype wire
